// File: rtl/fp_norm_seq.sv
// Multi-cycle significand normalizer: carry/zero screening, then a left shift of at most
// SHIFT_STEP bits per cycle with an exponent decrement clamped so the exponent never drops below 1.
`timescale 1ns/1ps
module fp_norm_seq #(
    parameter int unsigned SHIFT_STEP = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic        in_carry,
    input  logic [23:0] in_mant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [7:0]  out_exp,
    output logic [23:0] out_mant,
    output logic        out_zero,
    output logic        out_ovf,
    output logic        out_denorm,
    output logic        busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [4:0] STEP    = 5'(SHIFT_STEP);

    logic [1:0]  state_q, state_d;
    logic        sign_q, sign_d;
    logic [7:0]  exp_q, exp_d;
    logic        carry_q, carry_d;
    logic [23:0] mant_q, mant_d;
    logic [4:0]  rem_q, rem_d;
    logic        zero_q, zero_d;
    logic        ovf_q, ovf_d;
    logic        den_q, den_d;

    logic [8:0]  exp_inc;
    logic [7:0]  exp_lim;
    logic [4:0]  lz;
    logic [4:0]  rem_chk;
    logic [4:0]  step;
    logic [23:0] shifted;

    function automatic logic [4:0] lzc24(input logic [23:0] m);
        lzc24 = 5'd0;
        for (int unsigned i = 0; i < 24; i++) begin
            if (m[i]) lzc24 = 5'(23 - i);
        end
    endfunction

    // Shift budget is the smaller of the leading-zero count and what keeps the exponent at >= 1.
    always_comb begin
        exp_inc = {1'b0, exp_q} + 9'd1;
        exp_lim = (exp_q == 8'd0) ? 8'd0 : exp_q - 8'd1;
        lz      = lzc24(mant_q);
        rem_chk = ({3'b000, lz} < exp_lim) ? lz : exp_lim[4:0];
        step    = (rem_q > STEP) ? STEP : rem_q;
        shifted = mant_q << step;
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        carry_d = carry_q;
        mant_d  = mant_q;
        rem_d   = rem_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        den_d   = den_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = in_exp;
                    carry_d = in_carry;
                    mant_d  = in_mant;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                zero_d = 1'b0;
                ovf_d  = 1'b0;
                den_d  = 1'b0;
                rem_d  = 5'd0;
                if (carry_q) begin
                    state_d = S_DONE;
                    if (exp_inc >= 9'd255) begin
                        exp_d  = 8'hFF;
                        mant_d = '0;
                        ovf_d  = 1'b1;
                    end else begin
                        exp_d  = exp_inc[7:0];
                        mant_d = {1'b1, mant_q[23:1]};
                    end
                end else if (mant_q == 24'd0) begin
                    exp_d   = 8'd0;
                    zero_d  = 1'b1;
                    state_d = S_DONE;
                end else if (rem_chk == 5'd0) begin
                    state_d = S_DONE;
                    if (!mant_q[23]) begin
                        exp_d = 8'd0;
                        den_d = 1'b1;
                    end
                end else begin
                    rem_d   = rem_chk;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                mant_d = shifted;
                exp_d  = exp_q - {3'b000, step};
                rem_d  = rem_q - step;
                if (rem_q == step) begin
                    state_d = S_DONE;
                    if (!shifted[23]) begin
                        exp_d = 8'd0;
                        den_d = 1'b1;
                    end
                end
            end
            default: begin
                if (out_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            carry_q <= 1'b0;
            mant_q  <= '0;
            rem_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            den_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            carry_q <= carry_d;
            mant_q  <= mant_d;
            rem_q   <= rem_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            den_q   <= den_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign out_sign   = sign_q;
    assign out_exp    = exp_q;
    assign out_mant   = mant_q;
    assign out_zero   = zero_q;
    assign out_ovf    = ovf_q;
    assign out_denorm = den_q;
endmodule
